// File: rtl/rxd_score.sv
// rxd_score: UART receiver for the score link (8N1, LSB first).
// Deserialises bytes from RxD, strobes data_valid per good frame and splits
// the byte into two 4-bit player scores.
// Optional build macro: RXD_PARITY_EN selects 8E1 framing with a parity check;
// when undefined the frame is 8N1 and parity_error is tied low.
module rxd_score #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic [3:0] points_first_player,
    output logic [3:0] points_second_player,
    output logic       frame_error,
    output logic       parity_error
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RXD_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic             r_rx_meta;
    logic             r_rx_s;
    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_baud;
    logic [CNT_W-1:0] w_baud_d;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_data_valid;
    logic             r_frame_error;
    logic             w_baud_tick;
    logic             w_shift_en;
    logic             w_bit_clr;
    logic             w_valid_d;
    logic             w_ferr_d;
    logic             w_par_ok;

`ifdef RXD_PARITY_EN
    logic r_par;
    logic r_parity_error;
    logic w_par_en;
    logic w_perr_d;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign w_par_ok = ~(^{r_shift, r_par});
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_baud_tick = (r_baud == BAUD_LAST);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RxD;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Next-state decode and per-state sampling strobes.
    always_comb begin
        w_state_d  = r_state;
        w_shift_en = 1'b0;
        w_bit_clr  = 1'b0;
        w_valid_d  = 1'b0;
        w_ferr_d   = 1'b0;
`ifdef RXD_PARITY_EN
        w_par_en   = 1'b0;
        w_perr_d   = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_state_d = S_START;
            end
            S_START: begin
                // Mid-start sample; a high line here was only a glitch.
                if (r_baud == HALF_LAST) begin
                    if (r_rx_s) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_state_d = S_DATA;
                        w_bit_clr = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_baud_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef RXD_PARITY_EN
                        w_state_d = S_PARITY;
`else
                        w_state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef RXD_PARITY_EN
            S_PARITY: begin
                if (w_baud_tick) begin
                    w_par_en  = 1'b1;
                    w_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_tick) begin
                    if (r_rx_s) begin
                        w_state_d = S_IDLE;
                        if (w_par_ok) begin
                            w_valid_d = 1'b1;
                        end else begin
`ifdef RXD_PARITY_EN
                            w_perr_d = 1'b1;
`endif
                        end
                    end else begin
                        // Bad stop bit: park until the line idles so a break
                        // cannot spin out a stream of bogus frames.
                        w_ferr_d  = 1'b1;
                        w_state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_rx_s) w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Baud counter restarts on every state change and wraps each bit period.
    always_comb begin
        w_baud_d = r_baud + CNT_W'(1);
        if (w_state_d != r_state || r_state == S_IDLE || w_baud_tick) begin
            w_baud_d = '0;
        end
    end

    // FSM state and bit-timing counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_baud  <= w_baud_d;
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // Shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift       <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_shift_en) r_shift[r_bit_cnt] <= r_rx_s;
            if (w_valid_d) r_data <= r_shift;
            r_data_valid  <= w_valid_d;
            r_frame_error <= w_ferr_d;
        end
    end

`ifdef RXD_PARITY_EN
    // Captured parity bit and its error strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par          <= 1'b0;
            r_parity_error <= 1'b0;
        end else begin
            if (w_par_en) r_par <= r_rx_s;
            r_parity_error <= w_perr_d;
        end
    end

    assign parity_error = r_parity_error;
`else
    assign parity_error = 1'b0;
`endif

    assign data                 = r_data;
    assign data_valid           = r_data_valid;
    assign frame_error          = r_frame_error;
    assign points_first_player  = r_data[7:4];
    assign points_second_player = r_data[3:0];

endmodule

// File: tb/tb_rxd_score.sv
// tb_rxd_score: scoreboard bench for rxd_score, run with a short bit period.
// Build with RXD_PARITY_EN defined to exercise the 8E1 variant.
module tb_rxd_score;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;
`ifdef RXD_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic [3:0] points_first_player;
    logic [3:0] points_second_player;
    logic       frame_error;
    logic       parity_error;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    longint     cyc = 0;
    longint     t_prev = 0;
    longint     t_last = 0;
    logic [7:0] exp_data = 8'h00;

    rxd_score #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT    (HALF)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .RxD                 (RxD),
        .data                (data),
        .data_valid          (data_valid),
        .points_first_player (points_first_player),
        .points_second_player(points_second_player),
        .frame_error         (frame_error),
        .parity_error        (parity_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] k;
        if (!rst && (data_valid || frame_error || parity_error)) begin
            k = {data_valid, frame_error, parity_error};
            if (k == K_VALID) begin
                t_prev = t_last;
                t_last = cyc;
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got kind=%b data=%h, required no pulse", k, data);
            end else begin
                e = sb.pop_front();
                if (k !== e.kind) begin
                    n_errors++;
                    $display("FAIL pulse_kind: got %b, required %b", k, e.kind);
                end
                n_checks++;
                if (data !== e.data) begin
                    n_errors++;
                    $display("FAIL pulse_data: got %h, required %h", data, e.data);
                end
                n_checks++;
                if ({points_first_player, points_second_player} !== e.data) begin
                    n_errors++;
                    $display("FAIL pulse_points: got %0d/%0d, required %0d/%0d",
                             points_first_player, points_second_player,
                             e.data[7:4], e.data[3:0]);
                end
            end
        end
    end

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b);
        RxD = b;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic flip_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RXD_PARITY_EN
        drive_bit((^b) ^ flip_par);
`endif
        drive_bit(stop);
    endtask

    task automatic expect_pulse(input logic [2:0] kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * CPB && sb.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: %0d expected pulses outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RxD = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (data !== 8'h00) begin
            n_errors++; $display("FAIL reset_data: got %h, required 00", data);
        end
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b, required 0", data_valid);
        end
        n_checks++;
        if (frame_error !== 1'b0) begin
            n_errors++; $display("FAIL reset_ferr: got %b, required 0", frame_error);
        end
        n_checks++;
        if (parity_error !== 1'b0) begin
            n_errors++; $display("FAIL reset_perr: got %b, required 0", parity_error);
        end
        n_checks++;
        if ({points_first_player, points_second_player} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_points: got %0d/%0d, required 0/0",
                     points_first_player, points_second_player);
        end
        @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic();
        expect_pulse(K_VALID, 8'hEF);
        send_frame(8'hEF, 1'b1, 1'b0);
        drive_bit(1'b1);
        wait_drain("basic");
        exp_data = 8'hEF;
        n_checks++;
        if (points_first_player !== 4'd14 || points_second_player !== 4'd15) begin
            n_errors++;
            $display("FAIL basic_points: got %0d/%0d, required 14/15",
                     points_first_player, points_second_player);
        end
    endtask

    task automatic test_glitch();
        RxD = 1'b0;
        repeat (HALF / 2) @(posedge clk);
        RxD = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        n_checks++;
        if (data !== exp_data) begin
            n_errors++; $display("FAIL glitch_data: got %h, required %h", data, exp_data);
        end
        // A clean frame right after shows the receiver is back in idle.
        expect_pulse(K_VALID, 8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0);
        drive_bit(1'b1);
        wait_drain("glitch_follow");
        exp_data = 8'hC3;
    endtask

    task automatic test_frame_error();
        expect_pulse(K_VALID, 8'h35);
        send_frame(8'h35, 1'b1, 1'b0);
        drive_bit(1'b1);
        exp_data = 8'h35;
        expect_pulse(K_FERR, 8'h35);
        send_frame(8'h00, 1'b0, 1'b0);
        // Hold a break; no further frames may be decoded from it.
        repeat (4 * CPB) @(posedge clk);
        wait_drain("ferr");
        n_checks++;
        if (data !== 8'h35) begin
            n_errors++; $display("FAIL ferr_hold: got %h, required 35", data);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        expect_pulse(K_VALID, 8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        drive_bit(1'b1);
        wait_drain("ferr_recover");
        exp_data = 8'h12;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'hAA;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        RxD = b[4];
        repeat (HALF) @(posedge clk);
        rst = 1'b1;
        RxD = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (data !== 8'h00 || data_valid !== 1'b0 || frame_error !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_outputs: got data=%h dv=%b fe=%b, required 00 0 0",
                     data, data_valid, frame_error);
        end
        exp_data = 8'h00;
        repeat (12 * CPB) @(posedge clk);
        n_checks++;
        if (data !== 8'h00) begin
            n_errors++; $display("FAIL midrst_hold: got %h, required 00", data);
        end
        expect_pulse(K_VALID, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        drive_bit(1'b1);
        wait_drain("midrst_follow");
        exp_data = 8'h5A;
    endtask

    task automatic test_back_to_back();
        expect_pulse(K_VALID, 8'h01);
        expect_pulse(K_VALID, 8'h80);
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        drive_bit(1'b1);
        wait_drain("b2b");
        exp_data = 8'h80;
        n_checks++;
        if (t_last - t_prev != longint'(FRAME_BITS * CPB)) begin
            n_errors++;
            $display("FAIL b2b_spacing: got %0d cycles, required %0d",
                     t_last - t_prev, FRAME_BITS * CPB);
        end
    endtask

`ifdef RXD_PARITY_EN
    task automatic test_parity();
        expect_pulse(K_PERR, exp_data);
        send_frame(8'h03, 1'b1, 1'b1);
        drive_bit(1'b1);
        wait_drain("parity_bad");
        n_checks++;
        if (data !== exp_data) begin
            n_errors++; $display("FAIL parity_hold: got %h, required %h", data, exp_data);
        end
        expect_pulse(K_VALID, 8'h03);
        send_frame(8'h03, 1'b1, 1'b0);
        drive_bit(1'b1);
        wait_drain("parity_good");
        exp_data = 8'h03;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef RXD_PARITY_EN
        test_parity();
`endif
        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
